// File: rtl/ber_meter.sv
// ber_meter: self-synchronising PRBS bit-error-rate meter.
//
// All N = 2*BITS_PER_AXIS bits of a symbol are handled in parallel on each
// sym_clk_en. A local Fibonacci LFSR is aligned to the received stream. Bit
// errors are then counted over windows of 2^WINDOW_LOG2 symbols. Sync is
// dropped when a LOSS_BLK-symbol block collects LOSS_THRESH or more errors.
//
// State table:
//   SEARCH | loading received bits into the LFSR until LFSR_LEN bits are in
//   VERIFY | predicting each bit; waiting for SYNC_THRESH error-free bits
//   LOCKED | LFSR free-runs; errors counted per window and per loss block
//
// Ports:
//   sys_clk, reset_n        clock, async active-low reset
//   sym_clk_en              symbol strobe, slicer inputs valid when high
//   slicer_in_I/Q           sliced symbol, MSB first within each axis
//   restart                 synchronous resync request (wins over sym_clk_en)
//   error_count             errors of the last completed window
//   window_done             one-cycle pulse when error_count updates
//   locked                  high while LOCKED
//   sync_loss_count         saturating count of loss-of-sync events
module ber_meter #(
    parameter int BITS_PER_AXIS = 2,
    parameter int LFSR_LEN = 22,
    parameter logic [LFSR_LEN-1:0] LFSR_TAPS = 22'h200001,
    parameter int WINDOW_LOG2 = 20,
    parameter int SYNC_THRESH = 64,
    parameter int LOSS_BLK = 256,
    parameter int LOSS_THRESH = 32,
    parameter int CNT_W = WINDOW_LOG2 + $clog2(2 * BITS_PER_AXIS) + 1
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic                     sym_clk_en,
    input  logic [BITS_PER_AXIS-1:0] slicer_in_I,
    input  logic [BITS_PER_AXIS-1:0] slicer_in_Q,
    input  logic                     restart,
    output logic [CNT_W-1:0]         error_count,
    output logic                     window_done,
    output logic                     locked,
    output logic [7:0]               sync_loss_count
);

    localparam int N      = 2 * BITS_PER_AXIS;
    localparam int ERR_W  = $clog2(N + 1);
    localparam int FILL_W = $clog2(LFSR_LEN + N + 1);
    localparam int RUN_W  = $clog2(SYNC_THRESH + N + 1);
    localparam int BLK_W  = $clog2(LOSS_THRESH + N + 1);
    localparam int BCNT_W = (LOSS_BLK > 1) ? $clog2(LOSS_BLK) : 1;

    localparam logic [FILL_W-1:0] FILL_STEP = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_TGT  = FILL_W'(LFSR_LEN);
    localparam logic [RUN_W-1:0]  RUN_STEP  = RUN_W'(N);
    localparam logic [RUN_W-1:0]  RUN_TGT   = RUN_W'(SYNC_THRESH);
    localparam logic [BLK_W-1:0]  LOSS_TGT  = BLK_W'(LOSS_THRESH);
    localparam logic [BCNT_W-1:0] BLK_LAST  = BCNT_W'(LOSS_BLK - 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t state, state_next;

    logic [LFSR_LEN-1:0]    lfsr, lfsr_next, st;
    logic [FILL_W-1:0]      fill, fill_sum;
    logic [RUN_W-1:0]       run, run_sum;
    logic [CNT_W-1:0]       acc, win_sum;
    logic [BLK_W-1:0]       blk_acc, blk_sum;
    logic [WINDOW_LOG2-1:0] sym_cnt;
    logic [BCNT_W-1:0]      blk_cnt;
    logic [ERR_W-1:0]       err_sym;
    logic [N-1:0]           rx_vec;
    logic                   rx_bit, pred;
    logic                   win_last, blk_last, loss;

    // Oldest bit sits at the top: I[B-1] .. I[0], Q[B-1] .. Q[0].
    assign rx_vec = {slicer_in_I, slicer_in_Q};

    // Unrolled LFSR: every bit's prediction sees the state already advanced
    // by the earlier bits of the same symbol. Once locked the register is fed
    // from its own prediction, so received errors cannot corrupt it.
    always_comb begin
        st      = lfsr;
        err_sym = '0;
        rx_bit  = 1'b0;
        pred    = 1'b0;
        for (int i = 0; i < N; i++) begin
            rx_bit  = rx_vec[N-1-i];
            pred    = ^(st & LFSR_TAPS);
            err_sym = err_sym + ERR_W'(pred ^ rx_bit);
            st      = {st[LFSR_LEN-2:0], (state == LOCKED) ? pred : rx_bit};
        end
        lfsr_next = st;
    end

    assign fill_sum = fill + FILL_STEP;
    assign run_sum  = run + RUN_STEP;
    assign win_sum  = acc + CNT_W'(err_sym);
    assign blk_sum  = blk_acc + BLK_W'(err_sym);
    assign win_last = &sym_cnt;
    assign blk_last = (blk_cnt == BLK_LAST);
    assign loss     = (blk_sum >= LOSS_TGT);

    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = SEARCH;
        end else if (sym_clk_en) begin
            case (state)
                SEARCH:  if (fill_sum >= FILL_TGT) state_next = VERIFY;
                VERIFY:  if (err_sym == '0 && run_sum >= RUN_TGT) state_next = LOCKED;
                LOCKED:  if (loss) state_next = SEARCH;
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= SEARCH;
        else          state <= state_next;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr            <= '0;
            fill            <= '0;
            run             <= '0;
            acc             <= '0;
            blk_acc         <= '0;
            sym_cnt         <= '0;
            blk_cnt         <= '0;
            error_count     <= '0;
            window_done     <= 1'b0;
            locked          <= 1'b0;
            sync_loss_count <= '0;
        end else begin
            window_done <= 1'b0;
            locked      <= (state_next == LOCKED);
            if (restart) begin
                fill        <= '0;
                run         <= '0;
                acc         <= '0;
                blk_acc     <= '0;
                sym_cnt     <= '0;
                blk_cnt     <= '0;
                error_count <= '0;
            end else if (sym_clk_en) begin
                lfsr <= lfsr_next;
                case (state)
                    SEARCH: begin
                        fill <= (state_next == VERIFY) ? '0 : fill_sum;
                        run  <= '0;
                    end
                    VERIFY: begin
                        run <= (err_sym != '0 || state_next == LOCKED) ? '0 : run_sum;
                        if (state_next == LOCKED) begin
                            acc     <= '0;
                            blk_acc <= '0;
                            sym_cnt <= '0;
                            blk_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        sym_cnt <= sym_cnt + WINDOW_LOG2'(1);
                        blk_cnt <= blk_last ? '0 : blk_cnt + BCNT_W'(1);
                        if (win_last) begin
                            error_count <= win_sum;
                            acc         <= '0;
                            window_done <= 1'b1;
                        end else begin
                            acc <= win_sum;
                        end
                        // A window ending on the loss symbol has already
                        // latched above; only the partial window is dropped.
                        if (loss) begin
                            if (sync_loss_count != 8'hFF)
                                sync_loss_count <= sync_loss_count + 8'd1;
                            acc     <= '0;
                            blk_acc <= '0;
                            sym_cnt <= '0;
                            blk_cnt <= '0;
                            fill    <= '0;
                            run     <= '0;
                        end else begin
                            blk_acc <= blk_last ? '0 : blk_sum;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ber_meter.md
# ber_meter

Parametrised, self-synchronising bit-error-rate meter for the QPSK/16-QAM receive path; the successor to the fixed 2^20-symbol BER checker. It sits after the slicer on the symbol-rate enable and processes all 2·BITS_PER_AXIS bits of each symbol in parallel, with no sample-rate serialiser. A SEARCH/VERIFY/LOCKED state machine aligns a local PRBS LFSR to the received stream. It then counts bit errors over programmable windows and declares loss of sync when the error density gets too high.

## Interface
- BITS_PER_AXIS, 2: slicer bits per axis (1 = QPSK, 2 = 16-QAM); N = 2·BITS_PER_AXIS bits per symbol
- LFSR_LEN, 22: PRBS register length
- LFSR_TAPS, 22'h200001: feedback mask, bit k set ⇒ state bit k XORed into the new bit
- WINDOW_LOG2, 20: measurement window = 2^WINDOW_LOG2 symbols
- SYNC_THRESH, 64: consecutive error-free bits required to lock
- LOSS_BLK, 256: loss-detect block length in symbols
- LOSS_THRESH, 32: errors within one loss block that force resync
- CNT_W, WINDOW_LOG2+$clog2(N)+1: error counter width
- sys_clk  in  1  system clock, all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- sym_clk_en  in  1  one-cycle symbol strobe; slicer inputs are valid when it is high
- slicer_in_I  in  BITS_PER_AXIS  sliced I symbol
- slicer_in_Q  in  BITS_PER_AXIS  sliced Q symbol
- restart  in  1  synchronous pulse: abandon the measurement and resynchronise
- error_count  out  CNT_W  bit errors of the last completed window (latched)
- window_done  out  1  one-cycle pulse when error_count updates
- locked  out  1  high while the state is LOCKED
- sync_loss_count  out  8  loss-of-sync events since reset; saturates at 255

## Operation
- Bit order per symbol, oldest first: I[B-1]…I[0], Q[B-1]…Q[0].
- Fibonacci LFSR: predicted bit p = XOR(state & LFSR_TAPS). The state shifts left by 1 per bit, with the incoming bit entering at bit 0. This is unrolled N times per symbol, and each later bit's prediction uses the updated state.
- SEARCH (reset state): on each symbol, shift in the received bits. The fill counter adds N; when fill ≥ LFSR_LEN, go to VERIFY.
- VERIFY: compare p against each received bit, then shift in the received bits.
  - Symbol with no mismatches: run += N. Any mismatch: run = 0, stay in VERIFY.
  - run ≥ SYNC_THRESH ⇒ go to LOCKED and clear the window accumulators.
- LOCKED: the LFSR free-runs, shifting in p rather than the received bits.
  - err_sym = popcount(p XOR rx), range 0..N; it is added to both the window accumulator and the block accumulator.
  - Window: the symbol counter wraps at 2^WINDOW_LOG2. On the last symbol, error_count ← acc + err_sym, acc ← 0, window_done pulses.
  - Loss: if the block accumulator reaches ≥ LOSS_THRESH, go to SEARCH, increment sync_loss_count (saturating), and discard the partial window; error_count holds. At each LOSS_BLK symbol boundary the block accumulator clears.
  - If a loss and a window end fall on the same symbol, the window latches first, then the state goes to SEARCH.
- restart: go to SEARCH; fill, run, acc, block accumulator, symbol counter and error_count clear; sync_loss_count holds. restart beats a coincident sym_clk_en, so that symbol is dropped.
- No state changes occur on cycles without sym_clk_en.

## Timing
- reset_n low: state = SEARCH, LFSR = 0, all counters = 0, error_count = 0, window_done = 0, locked = 0, sync_loss_count = 0.
- All outputs are registered. Updates appear on the edge after the sym_clk_en cycle that caused them (latency 1 sys_clk).
- window_done is high for exactly 1 sys_clk cycle.
- locked rises 1 cycle after the VERIFY symbol that reaches SYNC_THRESH, and falls 1 cycle after the loss symbol or restart.
- Minimum lock time for an error-free stream with the defaults: ceil(22/4) + ceil(64/4) = 6 + 16 = 22 symbols.
- sym_clk_en may be asserted every cycle; no throughput limit.

## Test plan
- Error-free PRBS22 stream, 16-QAM, sym_clk_en every 4 cycles ⇒ locked rises after symbol 22. With WINDOW_LOG2=4: window_done every 16 symbols and error_count = 0.
- Locked, WINDOW_LOG2=4, flip one I bit in 3 symbols and both Q bits in 1 symbol ⇒ next error_count = 5. Following clean window ⇒ 0.
- Locked, LOSS_THRESH=32: send random data ⇒ locked drops within one LOSS_BLK, sync_loss_count = 1, error_count keeps its prior value. Clean PRBS then resumes ⇒ relock.
- Loss and window end on the same symbol ⇒ window_done pulses with the latched count, and locked drops in the same cycle.
- restart coincident with sym_clk_en mid-window ⇒ error_count = 0, locked = 0, that symbol is not counted. reset_n asserted mid-window ⇒ all outputs 0 asynchronously.
- BITS_PER_AXIS=1 (QPSK), error-free ⇒ lock after ceil(22/2) + 32 = 43 symbols. Flip both bits in one symbol ⇒ error_count = 2.
